// File: rtl/key_fifo.sv
// Keystroke FIFO between keyboard_controller and a stalling consumer.
// Show-ahead read port; a backspace key removes the newest unread entry.
module key_fifo #(
    parameter int unsigned DEPTH        = 8,
    parameter logic [7:0]  BACKSPACE    = 8'h08,
    parameter bit          EN_BACKSPACE = 1'b1
) (
    input  logic                       clk,
    input  logic                       nRST,
    input  logic                       keyReady,
    input  logic [7:0]                 savedByte,
    input  logic                       rdReady,
    output logic                       rdValid,
    output logic [7:0]                 rdData,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       clearOverflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          key_prev;

    logic          key_ev;
    logic          is_bs;
    logic          pop;
    logic          push;
    logic          drop;
    logic          bs;
    logic [CW-1:0] post_pop;
    logic [CW-1:0] cnt_next;

    always_comb begin
        empty    = (cnt == '0);
        full     = (cnt == DEPTH_C);
        rdValid  = ~empty;
        rdData   = empty ? 8'h00 : mem[rd_ptr];
        count    = cnt;
        overflow = ovf;

        key_ev   = keyReady & ~key_prev;
        is_bs    = EN_BACKSPACE && (savedByte == BACKSPACE);
        pop      = rdValid & rdReady;
        // The key event sees occupancy after this cycle's pop.
        post_pop = cnt - CW'(pop);
        push     = key_ev & ~is_bs & (post_pop < DEPTH_C);
        drop     = key_ev & ~is_bs & (post_pop == DEPTH_C);
        bs       = key_ev & is_bs & (post_pop != '0);
        cnt_next = post_pop + CW'(push) - CW'(bs);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= savedByte;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            key_prev <= 1'b0;
        end else begin
            key_prev <= keyReady;
            cnt      <= cnt_next;
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end else if (bs) begin
                wr_ptr <= wr_ptr - PW'(1);
            end
            // A drop wins over a simultaneous clear.
            if (drop) begin
                ovf <= 1'b1;
            end else if (clearOverflow) begin
                ovf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_key_fifo.sv
// Self-checking bench for key_fifo: directed scenarios plus random
// traffic compared every cycle against a queue-based reference model.
module tb_key_fifo;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       keyReady = 1'b0;
    logic [7:0] savedByte = 8'h00;
    logic       rdReady = 1'b0;
    logic       rdValid;
    logic [7:0] rdData;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clearOverflow = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_prev = 1'b0;

    key_fifo #(.DEPTH(DEPTH), .BACKSPACE(8'h08), .EN_BACKSPACE(1'b1)) dut (
        .clk(clk),
        .nRST(nRST),
        .keyReady(keyReady),
        .savedByte(savedByte),
        .rdReady(rdReady),
        .rdValid(rdValid),
        .rdData(rdData),
        .count(count),
        .full(full),
        .empty(empty),
        .overflow(overflow),
        .clearOverflow(clearOverflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] exp_data;
        exp_data = (q.size() > 0) ? q[0] : 8'h00;
        check({tag, ".rdValid"}, 32'(rdValid), 32'(q.size() > 0));
        check({tag, ".rdData"}, 32'(rdData), 32'(exp_data));
        check({tag, ".count"}, 32'(count), 32'(q.size()));
        check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    // Reference behaviour for one clock: pop first, then the key event.
    task automatic model_step();
        logic ev;
        logic dropped;
        dropped = 1'b0;
        ev = keyReady && !m_prev;
        if (rdReady && q.size() > 0) void'(q.pop_front());
        if (ev) begin
            if (savedByte == 8'h08) begin
                if (q.size() > 0) void'(q.pop_back());
            end else if (q.size() < DEPTH) begin
                q.push_back(savedByte);
            end else begin
                dropped = 1'b1;
            end
        end
        if (dropped) m_ovf = 1'b1;
        else if (clearOverflow) m_ovf = 1'b0;
        m_prev = keyReady;
    endtask

    task automatic cyc(input logic kr, input logic [7:0] b,
                       input logic rr, input logic co, input string tag);
        keyReady = kr;
        savedByte = b;
        rdReady = rr;
        clearOverflow = co;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic key(input logic [7:0] b, input logic rr, input string tag);
        cyc(1'b1, b, rr, 1'b0, tag);
        cyc(1'b0, b, rr, 1'b0, tag);
    endtask

    task automatic do_reset();
        keyReady = 1'b0;
        rdReady = 1'b0;
        clearOverflow = 1'b0;
        nRST = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_prev = 1'b0;
        #2;
        check_all("reset");
        @(negedge clk);
        nRST = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic kr;
        logic rr;
        logic co;
        logic [7:0] b;

        do_reset();

        // single key, show-ahead next cycle, held stable
        cyc(1'b1, 8'h48, 1'b0, 1'b0, "t1_key");
        check("t1_data", 32'(rdData), 32'h48);
        check("t1_count", 32'(count), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, "t1_hold");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, "t1_hold");
        check("t1_hold_data", 32'(rdData), 32'h48);

        // held strobe counts once
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h41, 1'b0, 1'b0, "t2_held");
        cyc(1'b0, 8'h41, 1'b0, 1'b0, "t2_low");
        check("t2_count", 32'(count), 32'd1);

        // backspace removes newest
        do_reset();
        key(8'h41, 1'b0, "t3_k");
        key(8'h42, 1'b0, "t3_k");
        key(8'h43, 1'b0, "t3_k");
        key(8'h08, 1'b0, "t3_bs");
        check("t3_count", 32'(count), 32'd2);
        check("t3_pop0", 32'(rdData), 32'h41);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "t3_pop");
        check("t3_pop1", 32'(rdData), 32'h42);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "t3_pop");
        check("t3_empty", 32'(empty), 32'd1);
        check("t3_data0", 32'(rdData), 32'h00);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "t3_idle_rd");

        // overflow on ninth key, then clear
        do_reset();
        for (int i = 0; i < 9; i++) key(8'h30 + 8'(i), 1'b0, "t4_fill");
        check("t4_full", 32'(full), 32'd1);
        check("t4_count", 32'(count), 32'd8);
        check("t4_ovf", 32'(overflow), 32'd1);
        cyc(1'b1, 8'h77, 1'b0, 1'b1, "t4_drop_clr");
        check("t4_ovf_kept", 32'(overflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, "t4_clr");
        check("t4_ovf_clr", 32'(overflow), 32'd0);

        // push and pop while full
        do_reset();
        for (int i = 0; i < 8; i++) key(8'h60 + 8'(i), 1'b0, "t5_fill");
        cyc(1'b1, 8'h5A, 1'b1, 1'b0, "t5_pushpop");
        check("t5_count", 32'(count), 32'd8);
        check("t5_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "t5_drain");
        check("t5_last", 32'(rdData), 32'h5A);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "t5_drain");

        // backspace and pop of the only entry
        do_reset();
        key(8'h33, 1'b0, "t6_k");
        check("t6_before", 32'(rdData), 32'h33);
        cyc(1'b1, 8'h08, 1'b1, 1'b0, "t6_bs_pop");
        check("t6_count", 32'(count), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, "t6_low");
        key(8'h51, 1'b0, "t6_burst");
        key(8'h52, 1'b0, "t6_burst");
        cyc(1'b1, 8'h53, 1'b0, 1'b0, "t6_burst");
        nRST = 1'b0;
        keyReady = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_prev = 1'b0;
        #2;
        check("t6_rst_empty", 32'(empty), 32'd1);
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_valid", 32'(rdValid), 32'd0);
        @(negedge clk);
        nRST = 1'b1;
        @(posedge clk);
        #1;
        check_all("t6_after");

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            kr = ($urandom_range(0, 1) == 1);
            rr = ($urandom_range(0, 9) < 3);
            co = ($urandom_range(0, 15) == 0);
            b = ($urandom_range(0, 4) == 0) ? 8'h08 : 8'($urandom);
            cyc(kr, b, rr, co, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
